// File: rtl/linear_array_capture.sv
// Linear-sensor readout sequencer driving N_CH shared-clock serial ADCs.
// Produces SI/sensor_clk timing and one deserialised sample per pixel per channel.
module linear_array_capture #(
  parameter int N_CH     = 2,
  parameter int DATA_W   = 12,
  parameter int ADC_LEAD = 4,
  parameter int N_PIX    = 128,
  parameter int PIX_CYC  = 40,
  parameter int SETTLE   = 2,
  parameter int PIX_W    = 7
) (
  input  logic                     clk_20M,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     continuous,
  input  logic [15:0]              int_clks,
  input  logic [N_CH-1:0]          adc_sdata,
  output logic                     sensor_clk,
  output logic                     si,
  output logic                     adc_sclk,
  output logic                     adc_cs_n,
  output logic [N_CH*DATA_W-1:0]   data,
  output logic                     data_valid,
  output logic [PIX_W-1:0]         pix_idx,
  output logic                     frame_start,
  output logic                     frame_done,
  output logic                     busy
);

  localparam int CONV_BITS = ADC_LEAD + DATA_W;
  localparam int SC_W      = $clog2(PIX_CYC);

  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(PIX_CYC - 1);
  localparam logic [SC_W-1:0]  SC_HALF  = SC_W'(PIX_CYC / 2);
  localparam logic [SC_W-1:0]  SI_BEG   = SC_W'(PIX_CYC - 4);
  localparam logic [SC_W-1:0]  SI_HOLD  = SC_W'(3);
  localparam logic [SC_W-1:0]  CONV_BEG = SC_W'(SETTLE);
  localparam logic [SC_W-1:0]  CONV_END = SC_W'(SETTLE + 2 * CONV_BITS);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(N_PIX - 1);
  localparam logic             SETTLE_ODD = (SETTLE % 2) == 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SI,
    S_PIXEL,
    S_FLUSH,
    S_INTEG
  } state_t;

  typedef struct packed {
    logic sensor_clk;
    logic si;
    logic adc_sclk;
    logic adc_cs_n;
  } pins_t;

  localparam pins_t PINS_RST = '{sensor_clk: 1'b0, si: 1'b0, adc_sclk: 1'b1, adc_cs_n: 1'b1};

  // Pin levels for a given slot position; evaluated on next-state values so
  // every external strobe leaves the block straight from a flop.
  function automatic pins_t decode(input state_t st, input logic [SC_W-1:0] sc,
                                   input logic [PIX_W-1:0] pix);
    pins_t p;
    logic  conv;
    p            = PINS_RST;
    conv         = (st == S_PIXEL) && (sc >= CONV_BEG) && (sc < CONV_END);
    p.sensor_clk = ((st == S_PIXEL) || (st == S_FLUSH) || (st == S_INTEG)) && (sc < SC_HALF);
    p.si         = ((st == S_SI) && (sc >= SI_BEG)) ||
                   ((st == S_PIXEL) && (pix == '0) && (sc <= SI_HOLD));
    p.adc_cs_n   = !conv;
    p.adc_sclk   = conv ? (sc[0] ^ SETTLE_ODD) : 1'b1;
    return p;
  endfunction

  state_t            state_q, state_d;
  logic [SC_W-1:0]   sc_q, sc_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [15:0]       gap_q, gap_d;
  logic [15:0]       int_q;
  pins_t             pins_q;
  logic              busy_q;
  logic              frame_done_q;
  logic              slot_end;
  logic              in_conv;
  logic              shift_en;
  logic              load_en;
  logic [DATA_W-1:0] shreg [N_CH];

  assign slot_end = (sc_q == SC_LAST);
  assign in_conv  = (state_q == S_PIXEL) && (sc_q >= CONV_BEG) && (sc_q < CONV_END);
  // o = sc - SETTLE is odd exactly when sc[0] differs from SETTLE's parity.
  assign shift_en = in_conv && (sc_q[0] ^ SETTLE_ODD);
  assign load_en  = (state_q == S_PIXEL) && (sc_q == CONV_END);

  // NOTE: every variable gets a default before the case so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SI;
      S_SI:    if (slot_end) state_d = S_PIXEL;
      S_PIXEL: if (slot_end && (pix_q == PIX_LAST)) state_d = S_FLUSH;
      S_FLUSH: begin
        if (slot_end) begin
          if (int_clks != 16'd0) state_d = S_INTEG;
          else                   state_d = continuous ? S_SI : S_IDLE;
        end
      end
      S_INTEG: begin
        if (slot_end && (gap_q == int_q - 16'd1))
          state_d = continuous ? S_SI : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    sc_d = ((state_q == S_IDLE) || slot_end) ? '0 : sc_q + 1'b1;

    pix_d = pix_q;
    if (state_q == S_SI)                    pix_d = '0;
    else if ((state_q == S_PIXEL) && slot_end) pix_d = pix_q + 1'b1;

    gap_d = gap_q;
    if (state_q == S_FLUSH)                 gap_d = '0;
    else if ((state_q == S_INTEG) && slot_end) gap_d = gap_q + 16'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops see
  // the pre-edge values of one another, independent of statement order.
  always_ff @(posedge clk_20M or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      sc_q         <= '0;
      pix_q        <= '0;
      gap_q        <= '0;
      int_q        <= '0;
      pins_q       <= PINS_RST;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sc_q         <= sc_d;
      pix_q        <= pix_d;
      gap_q        <= gap_d;
      pins_q       <= decode(state_d, sc_d, pix_d);
      busy_q       <= (state_d != S_IDLE);
      frame_done_q <= (state_d == S_FLUSH) && (sc_d == SC_LAST);
      if ((state_q == S_FLUSH) && slot_end) int_q <= int_clks;
    end
  end

  // NOTE: the deserialisers carry no reset; their contents are only ever
  // observed after a full conversion has overwritten them.
  always_ff @(posedge clk_20M) begin
    if (shift_en) begin
      for (int c = 0; c < N_CH; c++)
        shreg[c] <= {shreg[c][DATA_W-2:0], adc_sdata[c]};
    end
  end

  // Leading bits simply fall off the top of the DATA_W-wide shifters.
  always_ff @(posedge clk_20M or negedge reset) begin
    if (!reset) begin
      data        <= '0;
      data_valid  <= 1'b0;
      pix_idx     <= '0;
      frame_start <= 1'b0;
    end else begin
      data_valid  <= load_en;
      frame_start <= load_en && (pix_q == '0);
      if (load_en) begin
        for (int c = 0; c < N_CH; c++)
          data[c*DATA_W +: DATA_W] <= shreg[c];
        pix_idx <= pix_q;
      end else if (state_q == S_SI) begin
        pix_idx <= '0;
      end
    end
  end

  assign sensor_clk = pins_q.sensor_clk;
  assign si         = pins_q.si;
  assign adc_sclk   = pins_q.adc_sclk;
  assign adc_cs_n   = pins_q.adc_cs_n;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_linear_array_capture.sv
// Self-checking bench for linear_array_capture: ADC bit-serial models plus a
// frame-level observer compared against timing/data rules computed here.
module tb_linear_array_capture;

  localparam int N_CH      = 2;
  localparam int DATA_W    = 12;
  localparam int ADC_LEAD  = 4;
  localparam int N_PIX     = 128;
  localparam int PIX_CYC   = 40;
  localparam int SETTLE    = 2;
  localparam int PIX_W     = 7;
  localparam int CONV_BITS = ADC_LEAD + DATA_W;

  logic                   clk_20M = 1'b0;
  logic                   reset;
  logic                   start;
  logic                   continuous;
  logic [15:0]            int_clks;
  logic [N_CH-1:0]        adc_sdata = '0;
  logic                   sensor_clk, si, adc_sclk, adc_cs_n;
  logic [N_CH*DATA_W-1:0] data;
  logic                   data_valid, frame_start, frame_done, busy;
  logic [PIX_W-1:0]       pix_idx;

  linear_array_capture #(
    .N_CH(N_CH), .DATA_W(DATA_W), .ADC_LEAD(ADC_LEAD), .N_PIX(N_PIX),
    .PIX_CYC(PIX_CYC), .SETTLE(SETTLE), .PIX_W(PIX_W)
  ) dut (
    .clk_20M(clk_20M), .reset(reset), .start(start), .continuous(continuous),
    .int_clks(int_clks), .adc_sdata(adc_sdata), .sensor_clk(sensor_clk), .si(si),
    .adc_sclk(adc_sclk), .adc_cs_n(adc_cs_n), .data(data), .data_valid(data_valid),
    .pix_idx(pix_idx), .frame_start(frame_start), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk_20M = ~clk_20M;

  int errors = 0;
  int checks = 0;

  // ADC models: new word per conversion, MSB first, changes on sclk rise.
  logic                   rand_data = 1'b0;
  logic [CONV_BITS-1:0]   word  [N_CH];
  logic [CONV_BITS-1:0]   fixed [N_CH];
  logic [N_CH*DATA_W-1:0] exp_word;
  logic [N_CH*DATA_W-1:0] exp_q [$];
  int                     bitn = 0;

  always @(negedge adc_cs_n) begin
    bitn = 0;
    for (int c = 0; c < N_CH; c++) begin
      word[c] = rand_data ? CONV_BITS'($urandom) : fixed[c];
      exp_word[c*DATA_W +: DATA_W] = word[c][DATA_W-1:0];
    end
    exp_q.push_back(exp_word);
  end

  always @(posedge adc_sclk) begin
    if (adc_cs_n === 1'b0 && bitn < CONV_BITS) begin
      for (int c = 0; c < N_CH; c++) adc_sdata[c] <= word[c][CONV_BITS-1-bitn];
      bitn++;
    end
  end

  // Frame observer statistics.
  int cyc, busy_first, busy_cyc, dv_n, pix_bad, data_bad, fs_bad, fd_n, fd_rel;
  int sck_rises, first_sck, si_hi, si_last, cs_run, sclk_run, cs_bad, sclk_bad;
  int conv_n, dv_late, cs_rise_cyc, exp_pix;
  int si_rises [$];
  bit timeout;

  task automatic observe(input int max_cyc);
    bit seen, done, p_sck, p_si, p_cs, p_sclk;
    cyc = 0; busy_first = -1; busy_cyc = 0; dv_n = 0; pix_bad = 0; data_bad = 0;
    fs_bad = 0; fd_n = 0; fd_rel = -1; sck_rises = 0; first_sck = -1; si_hi = 0;
    si_last = -1; cs_run = 0; sclk_run = 0; cs_bad = 0; sclk_bad = 0; conv_n = 0;
    dv_late = 0; cs_rise_cyc = -100; exp_pix = 0; si_rises.delete();
    seen = 0; done = 0;
    p_sck = sensor_clk; p_si = si; p_cs = adc_cs_n; p_sclk = adc_sclk;
    for (int n = 0; n < max_cyc; n++) begin
      if (busy) begin
        if (!seen) begin seen = 1; busy_first = cyc; end
        busy_cyc++;
      end
      if (sensor_clk && !p_sck) begin
        sck_rises++;
        if (first_sck < 0) first_sck = cyc;
      end
      if (si) begin
        si_hi++;
        if (!p_si) si_rises.push_back(cyc);
        si_last = cyc;
      end
      if (!adc_cs_n) begin
        cs_run++;
        if (adc_sclk && !p_sclk) sclk_run++;
      end else if (!p_cs) begin
        conv_n++;
        if (cs_run != 2 * CONV_BITS) cs_bad++;
        if (sclk_run != CONV_BITS) sclk_bad++;
        cs_run = 0; sclk_run = 0; cs_rise_cyc = cyc;
      end
      if (data_valid) begin
        dv_n++;
        if (int'(pix_idx) != exp_pix) pix_bad++;
        if (frame_start !== (exp_pix == 0)) fs_bad++;
        if (cyc - cs_rise_cyc != 1) dv_late++;
        if (exp_q.size() == 0) data_bad++;
        else if (data !== exp_q.pop_front()) data_bad++;
        exp_pix = (exp_pix + 1) % N_PIX;
      end else if (frame_start) begin
        fs_bad++;
      end
      if (frame_done) begin
        fd_n++;
        if (fd_rel < 0) fd_rel = cyc - busy_first;
      end
      p_sck = sensor_clk; p_si = si; p_cs = adc_cs_n; p_sclk = adc_sclk;
      if (seen && !busy) begin done = 1; break; end
      cyc++;
      @(negedge clk_20M);
    end
    timeout = !done;
  endtask

  task automatic pulse_start();
    @(negedge clk_20M); start = 1'b1;
    @(negedge clk_20M); start = 1'b0;
  endtask

  task automatic test_reset();
    int edges;
    logic p_sck;
    reset = 1'b0; start = 1'b0; continuous = 1'b0; int_clks = '0;
    repeat (5) @(negedge clk_20M);
    checks++;
    if ({sensor_clk, si, adc_sclk, adc_cs_n, data_valid, frame_start, frame_done, busy} !== 8'b0011_0000) begin
      errors++;
      $display("FAIL reset_pins: got %b want 00110000",
               {sensor_clk, si, adc_sclk, adc_cs_n, data_valid, frame_start, frame_done, busy});
    end
    checks++;
    if (data !== '0 || pix_idx !== '0) begin
      errors++; $display("FAIL reset_data: data=%h pix=%0d want 0/0", data, pix_idx);
    end
    reset = 1'b1;
    edges = 0; p_sck = sensor_clk;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk_20M);
      if (sensor_clk !== p_sck || busy !== 1'b0) edges++;
      p_sck = sensor_clk;
    end
    checks++;
    if (edges != 0) begin errors++; $display("FAIL idle_quiet: %0d activity cycles want 0", edges); end
    checks++;
    if ({adc_sclk, adc_cs_n, data_valid} !== 3'b110) begin
      errors++; $display("FAIL idle_adc: sclk/cs/dv=%b want 110", {adc_sclk, adc_cs_n, data_valid});
    end
  endtask

  task automatic test_single_frame();
    int exp_len;
    rand_data = 1'b0; continuous = 1'b0; int_clks = '0; exp_q.delete();
    exp_len = (N_PIX + 2) * PIX_CYC;
    pulse_start();
    observe(exp_len + 200);
    checks++; if (timeout) begin errors++; $display("FAIL single_timeout: busy never dropped"); end
    checks++; if (busy_cyc != exp_len) begin errors++; $display("FAIL single_busy_len: got %0d want %0d", busy_cyc, exp_len); end
    checks++; if (dv_n != N_PIX) begin errors++; $display("FAIL single_dv_count: got %0d want %0d", dv_n, N_PIX); end
    checks++; if (pix_bad != 0) begin errors++; $display("FAIL single_pix_seq: %0d bad want 0", pix_bad); end
    checks++; if (data_bad != 0) begin errors++; $display("FAIL single_data: %0d bad want 0 (last data=%h)", data_bad, data); end
    checks++; if (data !== {12'h3FF, 12'hA5C}) begin errors++; $display("FAIL single_last_data: got %h want 3ffa5c", data); end
    checks++; if (fs_bad != 0) begin errors++; $display("FAIL single_frame_start: %0d bad want 0", fs_bad); end
    checks++; if (fd_n != 1 || fd_rel != exp_len - 1) begin errors++; $display("FAIL single_frame_done: n=%0d at %0d want 1 at %0d", fd_n, fd_rel, exp_len - 1); end
    checks++; if (sck_rises != N_PIX + 1) begin errors++; $display("FAIL single_sck_pulses: got %0d want %0d", sck_rises, N_PIX + 1); end
    checks++; if (dv_late != 0) begin errors++; $display("FAIL single_dv_latency: %0d late want 0", dv_late); end
  endtask

  task automatic test_si_timing();
    rand_data = 1'b1; continuous = 1'b0; int_clks = '0; exp_q.delete();
    pulse_start();
    observe((N_PIX + 2) * PIX_CYC + 200);
    checks++; if (si_hi != 8) begin errors++; $display("FAIL si_width: got %0d want 8", si_hi); end
    checks++; if (si_rises.size() != 1 || si_rises[0] != first_sck - 4) begin
      errors++; $display("FAIL si_setup: rises=%0d sck=%0d want %0d", si_rises.size(), first_sck, first_sck - 4);
    end
    checks++; if (si_last != first_sck + 3) begin errors++; $display("FAIL si_hold: last=%0d want %0d", si_last, first_sck + 3); end
    checks++; if (first_sck - busy_first != PIX_CYC) begin errors++; $display("FAIL first_sck_pos: got %0d want %0d", first_sck - busy_first, PIX_CYC); end
    checks++; if (conv_n != N_PIX || cs_bad != 0) begin errors++; $display("FAIL cs_window: convs=%0d bad=%0d want %0d/0", conv_n, cs_bad, N_PIX); end
    checks++; if (sclk_bad != 0) begin errors++; $display("FAIL sclk_rises: %0d bad conversions want 0", sclk_bad); end
    checks++; if (data_bad != 0) begin errors++; $display("FAIL random_data: %0d bad want 0", data_bad); end
  endtask

  task automatic test_continuous_gap();
    int len1, len2;
    rand_data = 1'b1; continuous = 1'b1; int_clks = 16'd3; exp_q.delete();
    len1 = (N_PIX + 2 + 3) * PIX_CYC;
    len2 = (N_PIX + 2 + 7) * PIX_CYC;
    pulse_start();
    fork
      observe(len1 + len2 + 300);
      begin
        repeat (len1 - 60) @(negedge clk_20M);
        int_clks = 16'd7;
        repeat (2800) @(negedge clk_20M);
        continuous = 1'b0;
      end
    join
    checks++; if (timeout) begin errors++; $display("FAIL cont_timeout: busy never dropped"); end
    checks++; if (si_rises.size() != 2) begin errors++; $display("FAIL cont_si_count: got %0d want 2", si_rises.size()); end
    else begin
      checks++; if (si_rises[1] - si_rises[0] != len1) begin
        errors++; $display("FAIL cont_period: got %0d want %0d", si_rises[1] - si_rises[0], len1);
      end
    end
    checks++; if (busy_cyc != len1 + len2) begin errors++; $display("FAIL cont_busy_len: got %0d want %0d", busy_cyc, len1 + len2); end
    checks++; if (dv_n != 2 * N_PIX || pix_bad != 0) begin errors++; $display("FAIL cont_pix: dv=%0d bad=%0d want %0d/0", dv_n, pix_bad, 2 * N_PIX); end
    checks++; if (fd_n != 2) begin errors++; $display("FAIL cont_frame_done: got %0d want 2", fd_n); end
    checks++; if (sck_rises != 2 * (N_PIX + 1) + 3 + 7) begin errors++; $display("FAIL cont_sck: got %0d want %0d", sck_rises, 2 * (N_PIX + 1) + 10); end
    checks++; if (data_bad != 0 || fs_bad != 0) begin errors++; $display("FAIL cont_data: data_bad=%0d fs_bad=%0d want 0/0", data_bad, fs_bad); end
  endtask

  task automatic test_start_while_busy();
    int exp_len, late;
    rand_data = 1'b1; continuous = 1'b0; int_clks = '0; exp_q.delete();
    exp_len = (N_PIX + 2) * PIX_CYC;
    pulse_start();
    fork
      observe(exp_len + 200);
      begin
        repeat (1000) @(negedge clk_20M);
        start = 1'b1;
        @(negedge clk_20M);
        start = 1'b0;
      end
    join
    checks++; if (busy_cyc != exp_len || si_rises.size() != 1) begin
      errors++; $display("FAIL busy_start_len: len=%0d si=%0d want %0d/1", busy_cyc, si_rises.size(), exp_len);
    end
    checks++; if (dv_n != N_PIX || fd_n != 1 || data_bad != 0) begin
      errors++; $display("FAIL busy_start_frame: dv=%0d fd=%0d bad=%0d want %0d/1/0", dv_n, fd_n, data_bad, N_PIX);
    end
    late = 0;
    for (int n = 0; n < 100; n++) begin @(negedge clk_20M); if (busy) late++; end
    checks++; if (late != 0) begin errors++; $display("FAIL busy_start_idle: busy %0d cycles want 0", late); end
  endtask

  task automatic test_random_gap();
    int g, exp_len;
    for (int it = 0; it < 2; it++) begin
      g = $urandom_range(0, 4);
      rand_data = 1'b1; continuous = 1'b0; int_clks = 16'(g); exp_q.delete();
      exp_len = (N_PIX + 2 + g) * PIX_CYC;
      pulse_start();
      observe(exp_len + 200);
      checks++; if (busy_cyc != exp_len || fd_rel != (N_PIX + 2) * PIX_CYC - 1) begin
        errors++; $display("FAIL gap%0d_timing: len=%0d fd=%0d want %0d/%0d", g, busy_cyc, fd_rel, exp_len, (N_PIX + 2) * PIX_CYC - 1);
      end
      checks++; if (sck_rises != N_PIX + 1 + g || data_bad != 0) begin
        errors++; $display("FAIL gap%0d_pulses: sck=%0d bad=%0d want %0d/0", g, sck_rises, data_bad, N_PIX + 1 + g);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    bit found;
    int dv_seen;
    rand_data = 1'b1; continuous = 1'b0; int_clks = '0; exp_q.delete();
    pulse_start();
    found = 0;
    for (int n = 0; n < (N_PIX + 2) * PIX_CYC; n++) begin
      @(negedge clk_20M);
      if (data_valid && pix_idx == 7'd59) begin found = 1; break; end
    end
    if (found) begin
      found = 0;
      for (int n = 0; n < PIX_CYC; n++) begin
        @(negedge clk_20M);
        if (!adc_cs_n) begin found = 1; break; end
      end
    end
    checks++; if (!found) begin errors++; $display("FAIL midrst_reach: conversion at pixel 60 not seen"); end
    repeat (5) @(negedge clk_20M);
    #2 reset = 1'b0;
    #1;
    checks++; if ({adc_cs_n, adc_sclk, sensor_clk, busy, data_valid} !== 5'b11000) begin
      errors++; $display("FAIL midrst_pins: cs/sclk/sck/busy/dv=%b want 11000", {adc_cs_n, adc_sclk, sensor_clk, busy, data_valid});
    end
    dv_seen = 0;
    for (int n = 0; n < 20; n++) begin @(negedge clk_20M); if (data_valid) dv_seen++; end
    reset = 1'b1;
    for (int n = 0; n < 50; n++) begin @(negedge clk_20M); if (data_valid || busy) dv_seen++; end
    checks++; if (dv_seen != 0) begin errors++; $display("FAIL midrst_quiet: %0d active cycles want 0", dv_seen); end
    exp_q.delete();
    pulse_start();
    observe((N_PIX + 2) * PIX_CYC + 200);
    checks++; if (dv_n != N_PIX || pix_bad != 0 || data_bad != 0) begin
      errors++; $display("FAIL midrst_restart: dv=%0d pix_bad=%0d data_bad=%0d want %0d/0/0", dv_n, pix_bad, data_bad, N_PIX);
    end
  endtask

  initial begin
    fixed[0] = 16'h0A5C;
    fixed[1] = 16'h03FF;
    test_reset();
    test_single_frame();
    test_si_timing();
    test_continuous_gap();
    test_start_while_busy();
    test_random_gap();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/linear_array_capture.md
Name: linear_array_capture

Overview:
- Parametrised successor to the fixed two-channel sensor/ADC front end.
- Generates the linear-sensor SI and sensor_clk sequence and drives N_CH serial ADCs that share one chip select and one serial clock.
- Deserialises one sample per pixel per channel and presents it with pixel index and frame strobes to the softcore GPI / buffer logic.
- Adds two behaviours the earlier block lacks: single-shot or continuous frames, and a runtime-programmable integration gap.

Parameters:
- N_CH, 2, number of sensor/ADC channels sampled in parallel
- DATA_W, 12, ADC result width kept per channel
- ADC_LEAD, 4, leading bits per conversion that are discarded (CONV_BITS = ADC_LEAD + DATA_W)
- N_PIX, 128, pixels per sensor readout
- PIX_CYC, 40, clk_20M cycles per pixel slot; must be even and >= SETTLE + 2*CONV_BITS + 2
- SETTLE, 2, cycles from sensor_clk rise to adc_cs_n fall
- PIX_W, 7, pix_idx width; equals ceil(log2(N_PIX))

Ports:
- clk_20M  in  1  block clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request for a frame; honoured only in IDLE
- continuous  in  1  1 = start a new frame automatically after integration
- int_clks  in  16  integration gap in sensor_clk slots; sampled at end of FLUSH
- adc_sdata  in  N_CH  serial data, one bit per ADC, MSB first
- sensor_clk  out  1  sensor pixel clock
- si  out  1  sensor start-integration/readout pulse
- adc_sclk  out  1  shared ADC serial clock; idles high
- adc_cs_n  out  1  shared ADC chip select; active low
- data  out  N_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W]
- data_valid  out  1  one-cycle strobe marking data and pix_idx valid
- pix_idx  out  PIX_W  pixel number of the current data
- frame_start  out  1  pulses with data_valid for pixel 0
- frame_done  out  1  one-cycle pulse at end of FLUSH
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values (asserted asynchronously, mid-operation included): sensor_clk=0, si=0, adc_sclk=1, adc_cs_n=1, data=0, data_valid=0, pix_idx=0, frame_start=0, frame_done=0, busy=0. State returns to IDLE and all counters clear.
- States: IDLE -> SI_SLOT -> PIXEL (N_PIX slots) -> FLUSH (1 slot) -> INTEG (int_clks slots; skipped if 0) -> SI_SLOT if continuous=1, else IDLE.
- Every non-IDLE state is built from slots of PIX_CYC cycles, counted by slot counter sc = 0..PIX_CYC-1.
- IDLE exit: start=1 enters SI_SLOT on the next edge with sc=0. start is ignored while busy.
- sensor_clk:
  - High for sc < PIX_CYC/2 in PIXEL, FLUSH and INTEG slots.
  - Low for the whole SI_SLOT.
  - Low in IDLE.
- si:
  - High from sc = PIX_CYC-4 of SI_SLOT through sc = 3 of pixel-0 slot.
  - This gives 4 cycles of setup and 4 cycles of hold around the first sensor_clk rise.
  - Low at all other times.
- ADC conversion runs in PIXEL slots only. Let o = sc - SETTLE.
  - adc_cs_n = 0 for 0 <= o < 2*CONV_BITS.
  - adc_sclk = o[0] during conversion (falls at even o, rises at odd o); high otherwise.
  - Each adc_sdata bit is shifted into its per-channel register on cycles where o is odd.
  - CONV_BITS bits are captured, MSB first. The final DATA_W bits are kept; the ADC_LEAD leading bits are dropped.
- Output latency:
  - data_valid pulses at o = 2*CONV_BITS + 1, i.e. sc = SETTLE + 2*CONV_BITS + 1.
  - data and pix_idx update on that cycle and hold until the next strobe.
  - frame_start accompanies the data_valid strobe of pix_idx = 0.
- FLUSH: one extra sensor_clk pulse with no conversion. frame_done pulses at sc = PIX_CYC-1. int_clks is latched on that same cycle, so later changes to int_clks do not affect the current gap.
- continuous: evaluated at the end of the last INTEG slot, or at the end of FLUSH when int_clks = 0. Deasserting it mid-frame completes the frame and the gap, then returns to IDLE.
- pix_idx: counts 0..N_PIX-1 with no wrap inside a frame; resets to 0 at each SI_SLOT.
- Frame length: (N_PIX + 2 + int_clks) * PIX_CYC cycles.
- Fixed timing: no backpressure; consumers must accept each data_valid strobe.

Test Plan:
- Reset value check: hold reset low, then release with start=0 -> all outputs at their reset values, busy=0, no sensor_clk edge within 1000 cycles.
- Single frame: defaults, int_clks=0, continuous=0, one start pulse; ADC models return 0000_1010_0101_1100 on ch0 and 0000_0011_1111_1111 on ch1 ->
  - exactly 128 data_valid strobes, pix_idx 0..127;
  - every strobe shows data = {0x3FF, 0xA5C};
  - frame_start only on pix_idx 0;
  - frame_done 5200 cycles after start is accepted;
  - 129 sensor_clk pulses;
  - busy drops at 5200.
- SI timing: check si high exactly 8 cycles, straddling the first sensor_clk rise by 4 cycles on each side; check adc_cs_n low exactly 32 cycles per pixel with 16 adc_sclk rises.
- Continuous with gap: continuous=1, int_clks=3 -> second SI_SLOT begins 5320 cycles after the first. Clear continuous mid-frame 2 -> frame 2 completes, then IDLE.
- start while busy: pulse start during PIXEL -> no effect, frame timing unchanged.
- Reset mid-operation: assert reset during a conversion at pixel 60 -> adc_cs_n=1 and adc_sclk=1 immediately, no further data_valid. After release and a new start, pix_idx restarts at 0.
